// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp encoding, fault codes and lamp-index helpers shared by the traffic light
// monitor and its per-lamp sequence checkers.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED   = 3'b100;
    localparam logic [2:0] LAMP_AMBER = 3'b010;
    localparam logic [2:0] LAMP_GREEN = 3'b001;

    localparam int unsigned NUM_LAMPS     = 16;
    localparam int unsigned LAMPS_PER_GRP = 4;
    localparam int unsigned IDX_F1        = 0;
    localparam int unsigned IDX_R1        = 4;
    localparam int unsigned IDX_L1        = 8;
    localparam int unsigned IDX_C1        = 12;

    localparam int unsigned GRP_F = IDX_F1 / LAMPS_PER_GRP;
    localparam int unsigned GRP_L = IDX_L1 / LAMPS_PER_GRP;
    localparam int unsigned GRP_C = IDX_C1 / LAMPS_PER_GRP;

    typedef enum logic [2:0] {
        FcNone       = 3'd0,
        FcIllegal    = 3'd1,
        FcConflict   = 3'd2,
        FcSkipAmber  = 3'd3,
        FcShortAmber = 3'd4,
        FcAmberGreen = 3'd5
    } fault_code_t;

    function automatic logic lamp_legal(input logic [2:0] v);
        return (v == LAMP_RED) || (v == LAMP_AMBER) || (v == LAMP_GREEN);
    endfunction

    // Approaches are numbered 0..3 (1..4 externally); 1<->3 and 2<->4 face each other.
    function automatic int unsigned opposing_approach(input int unsigned appr);
        return (appr + 2) % LAMPS_PER_GRP;
    endfunction

    // True when lamps a and b may never be green together.
    function automatic logic lamps_conflict(input int unsigned a, input int unsigned b);
        int unsigned grp_a;
        int unsigned grp_b;
        int unsigned app_a;
        int unsigned app_b;
        logic        veh_a;
        logic        veh_b;
        logic        res;
        grp_a = a / LAMPS_PER_GRP;
        grp_b = b / LAMPS_PER_GRP;
        app_a = a % LAMPS_PER_GRP;
        app_b = b % LAMPS_PER_GRP;
        veh_a = (grp_a != GRP_C);
        veh_b = (grp_b != GRP_C);
        res   = 1'b0;
        if (veh_a && veh_b && ((app_a % 2) != (app_b % 2))) res = 1'b1;
        if (grp_a == GRP_L && grp_b == GRP_F && opposing_approach(app_a) == app_b) res = 1'b1;
        if (grp_b == GRP_L && grp_a == GRP_F && opposing_approach(app_b) == app_a) res = 1'b1;
        if (veh_a != veh_b) res = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// lamp_seq_checker: amber-duration counter and green/amber/red sequence check for one lamp.
module lamp_seq_checker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_AMBER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_cur,
    input  logic [2:0]  i_prv,
    input  logic        i_prv_valid,
    output fault_code_t o_code
);

    localparam int unsigned    CW      = $clog2(MIN_AMBER + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_AMBER);

    // After each edge r_cnt holds the consecutive-amber run ending at i_prv.
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = '0;
        if (i_cur == LAMP_AMBER) begin
            w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    always_comb begin
        o_code = FcNone;
        if (i_prv_valid) begin
            if (i_prv == LAMP_GREEN && i_cur == LAMP_RED) begin
                o_code = FcSkipAmber;
            end else if (i_prv == LAMP_AMBER && i_cur == LAMP_GREEN) begin
                o_code = FcAmberGreen;
            end else if (i_prv == LAMP_AMBER && i_cur == LAMP_RED && r_cnt < CNT_MAX) begin
                o_code = FcShortAmber;
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: samples the 16 lamp outputs, latches the first safety violation.
// Define TLM_FAULT_COUNT_EN to add the saturating per-cycle violation counter fault_count.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_AMBER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  f1,
    input  logic [2:0]  f2,
    input  logic [2:0]  f3,
    input  logic [2:0]  f4,
    input  logic [2:0]  r1,
    input  logic [2:0]  r2,
    input  logic [2:0]  r3,
    input  logic [2:0]  r4,
    input  logic [2:0]  l1,
    input  logic [2:0]  l2,
    input  logic [2:0]  l3,
    input  logic [2:0]  l4,
    input  logic [2:0]  c1,
    input  logic [2:0]  c2,
    input  logic [2:0]  c3,
    input  logic [2:0]  c4,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [3:0]  fault_lamp,
    output logic        flash_req
`ifdef TLM_FAULT_COUNT_EN
    ,
    output logic [15:0] fault_count
`endif
);

    logic [NUM_LAMPS-1:0][2:0] w_lamp_in;
    logic [NUM_LAMPS-1:0][2:0] r_cur;
    logic [NUM_LAMPS-1:0][2:0] r_prv;
    logic                      r_sampled;
    logic                      r_prv_valid;
    logic                      r_fault;
    fault_code_t               r_fault_code;
    logic [3:0]                r_fault_lamp;

    logic [NUM_LAMPS-1:0]      w_green;
    logic [NUM_LAMPS-1:0]      w_illegal;
    logic [NUM_LAMPS-1:0]      w_conf_low;
    fault_code_t               w_seq_code  [NUM_LAMPS];
    fault_code_t               w_lamp_code [NUM_LAMPS];
    fault_code_t               w_det_code;
    logic [3:0]                w_det_lamp;

    assign w_lamp_in = {c4, c3, c2, c1, l4, l3, l2, l1, r4, r3, r2, r1, f4, f3, f2, f1};

    // r_prv only holds a real sample once two edges have passed since reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur       <= {NUM_LAMPS{LAMP_RED}};
            r_prv       <= {NUM_LAMPS{LAMP_RED}};
            r_sampled   <= 1'b0;
            r_prv_valid <= 1'b0;
        end else begin
            r_cur       <= w_lamp_in;
            r_prv       <= r_cur;
            r_sampled   <= 1'b1;
            r_prv_valid <= r_sampled;
        end
    end

    for (genvar g = 0; g < NUM_LAMPS; g++) begin : g_lamp
        lamp_seq_checker #(
            .MIN_AMBER (MIN_AMBER)
        ) u_seq_chk (
            .clk         (clk),
            .rst         (rst),
            .i_cur       (r_cur[g]),
            .i_prv       (r_prv[g]),
            .i_prv_valid (r_prv_valid),
            .o_code      (w_seq_code[g])
        );
    end

    always_comb begin
        w_green     = '0;
        w_illegal   = '0;
        w_conf_low  = '0;
        w_lamp_code = '{default: FcNone};
        w_det_code  = FcNone;
        w_det_lamp  = '0;
        for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
            w_green[i]   = (r_cur[i] == LAMP_GREEN);
            w_illegal[i] = !lamp_legal(r_cur[i]);
        end
        // Flag only the lower index of each conflicting pair.
        for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
            for (int unsigned j = i + 1; j < NUM_LAMPS; j++) begin
                if (w_green[i] && w_green[j] && lamps_conflict(i, j)) w_conf_low[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
            w_lamp_code[i] = w_illegal[i]  ? FcIllegal  :
                             w_conf_low[i] ? FcConflict : w_seq_code[i];
        end
        // Descending scan with <= leaves the lowest code, ties broken by lowest index.
        for (int i = int'(NUM_LAMPS) - 1; i >= 0; i--) begin
            if (w_lamp_code[i] != FcNone &&
                (w_det_code == FcNone || w_lamp_code[i] <= w_det_code)) begin
                w_det_code = w_lamp_code[i];
                w_det_lamp = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault      <= 1'b0;
            r_fault_code <= FcNone;
            r_fault_lamp <= '0;
        end else if (w_det_code != FcNone && (!r_fault || fault_clr)) begin
            r_fault      <= 1'b1;
            r_fault_code <= w_det_code;
            r_fault_lamp <= w_det_lamp;
        end else if (fault_clr) begin
            r_fault      <= 1'b0;
            r_fault_code <= FcNone;
            r_fault_lamp <= '0;
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign fault_lamp = r_fault_lamp;
    assign flash_req  = r_fault;

`ifdef TLM_FAULT_COUNT_EN
    logic [15:0] r_fault_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault_count <= '0;
        end else if (w_det_code != FcNone && r_fault_count != 16'hFFFF) begin
            r_fault_count <= r_fault_count + 16'd1;
        end
    end

    assign fault_count = r_fault_count;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed stimulus with a cycle-tagged scoreboard queue and a
// negedge monitor. Checks fault_count as well when TLM_FAULT_COUNT_EN is defined.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    typedef struct {
        int          cyc;
        logic        fault;
        logic [2:0]  code;
        logic [3:0]  lamp;
        logic        chk_cnt;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        fault_clr;
    logic [2:0]  lamp [16];
    logic        fault;
    logic [2:0]  fault_code;
    logic [3:0]  fault_lamp;
    logic        flash_req;
`ifdef TLM_FAULT_COUNT_EN
    logic [15:0] fault_count;
`endif

    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    traffic_light_monitor #(
        .MIN_AMBER (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .f1         (lamp[0]),
        .f2         (lamp[1]),
        .f3         (lamp[2]),
        .f4         (lamp[3]),
        .r1         (lamp[4]),
        .r2         (lamp[5]),
        .r3         (lamp[6]),
        .r4         (lamp[7]),
        .l1         (lamp[8]),
        .l2         (lamp[9]),
        .l3         (lamp[10]),
        .l4         (lamp[11]),
        .c1         (lamp[12]),
        .c2         (lamp[13]),
        .c3         (lamp[14]),
        .c4         (lamp[15]),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_lamp (fault_lamp),
        .flash_req  (flash_req)
`ifdef TLM_FAULT_COUNT_EN
        ,
        .fault_count (fault_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_item(input exp_t e);
        logic ok;
        ok = (fault === e.fault) && (flash_req === e.fault) &&
             (fault_code === e.code) && (fault_lamp === e.lamp);
`ifdef TLM_FAULT_COUNT_EN
        if (e.chk_cnt) ok = ok && (fault_count === e.cnt);
`endif
        n_cmp++;
        if (!ok) begin
            n_fail++;
`ifdef TLM_FAULT_COUNT_EN
            $display("FAIL %s: got fault=%b flash=%b code=%0d lamp=%0d cnt=%0d, want fault=%b code=%0d lamp=%0d cnt=%0d",
                     e.name, fault, flash_req, fault_code, fault_lamp, fault_count,
                     e.fault, e.code, e.lamp, e.cnt);
`else
            $display("FAIL %s: got fault=%b flash=%b code=%0d lamp=%0d, want fault=%b code=%0d lamp=%0d",
                     e.name, fault, flash_req, fault_code, fault_lamp, e.fault, e.code, e.lamp);
`endif
        end
    endtask

    // Monitor: pops every expectation tagged for the current cycle.
    always @(negedge clk) begin : mon
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc_cnt) check_item(sb[i]);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic all_red();
        foreach (lamp[i]) lamp[i] = 3'b100;
    endtask

    task automatic push_exp(input int dly, input logic f, input logic [2:0] c,
                            input logic [3:0] l, input logic chk, input logic [15:0] cnt,
                            input string nm);
        exp_t e;
        e.cyc = cyc_cnt + dly;
        e.fault = f;
        e.code = c;
        e.lamp = l;
        e.chk_cnt = chk;
        e.cnt = cnt;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Inputs changed now are sampled at the next edge and reflected one edge later (dly = 2).
    task automatic expect_out(input int dly, input logic f, input logic [2:0] c,
                              input logic [3:0] l, input string nm);
        push_exp(dly, f, c, l, 1'b0, 16'd0, nm);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fault_clr = 1'b0;
        all_red();
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        fault_clr = 1'b0;
        all_red();
        tick(1);
        // Illegal lamp while reset is held must not latch.
        lamp[11] = 3'b011;
        expect_out(1, 1'b0, 3'd0, 4'd0, "reset_hold");
        tick(2);
        all_red();
        rst = 1'b1;

        // f1 green alone for 10 cycles: no fault.
        lamp[IDX_F1] = 3'b001;
        for (int k = 0; k < 10; k++) begin
            push_exp(2, 1'b0, 3'd0, 4'd0, 1'b1, 16'd0, "f1_green_quiet");
            tick(1);
        end
        // f1 + f2 green: conflict, lamp 0, two edges after sampling.
        lamp[IDX_F1 + 1] = 3'b001;
        expect_out(1, 1'b0, 3'd0, 4'd0, "conflict_latency");
        expect_out(2, 1'b1, 3'd2, 4'd0, "conflict_f1_f2");
        tick(3);
        lamp[IDX_L1 + 3] = 3'b011;
        expect_out(2, 1'b1, 3'd2, 4'd0, "sticky");
        tick(3);

        // f3 amber held 3 cycles then red: legal.
        do_reset();
        lamp[2] = 3'b001;
        tick(1);
        lamp[2] = 3'b010;
        tick(3);
        lamp[2] = 3'b100;
        expect_out(2, 1'b0, 3'd0, 4'd0, "amber3_ok");
        expect_out(3, 1'b0, 3'd0, 4'd0, "amber3_ok_hold");
        tick(4);

        // f3 amber held 2 cycles: short amber on lamp 2.
        do_reset();
        lamp[2] = 3'b001;
        tick(1);
        lamp[2] = 3'b010;
        tick(2);
        lamp[2] = 3'b100;
        expect_out(1, 1'b0, 3'd0, 4'd0, "short_amber_latency");
        expect_out(2, 1'b1, 3'd4, 4'd2, "short_amber");
        tick(3);

        // f1 amber back to green.
        do_reset();
        lamp[IDX_F1] = 3'b001;
        tick(1);
        lamp[IDX_F1] = 3'b010;
        tick(1);
        lamp[IDX_F1] = 3'b001;
        expect_out(2, 1'b1, 3'd5, 4'd0, "amber_green");
        tick(3);

        // r1 green straight to red.
        do_reset();
        lamp[IDX_R1] = 3'b001;
        tick(1);
        lamp[IDX_R1] = 3'b100;
        expect_out(2, 1'b1, 3'd3, 4'd4, "skip_amber");
        tick(3);

        // Skip on lamp 0 with illegal lamps 9 and 14: illegal wins, lowest index.
        do_reset();
        lamp[IDX_F1] = 3'b001;
        tick(1);
        lamp[IDX_F1] = 3'b100;
        lamp[9]  = 3'b111;
        lamp[14] = 3'b000;
        expect_out(2, 1'b1, 3'd1, 4'd9, "priority_illegal");
        tick(3);

        // Same-axis greens are legal; adding l1 conflicts with opposing f3.
        do_reset();
        lamp[IDX_F1] = 3'b001;
        lamp[2]      = 3'b001;
        lamp[IDX_R1] = 3'b001;
        expect_out(2, 1'b0, 3'd0, 4'd0, "same_axis_ok");
        tick(2);
        lamp[IDX_L1] = 3'b001;
        expect_out(2, 1'b1, 3'd2, 4'd2, "left_vs_opposing_f");
        tick(3);

        // l4 illegal, clear with legal lamps, then clear racing a new conflict.
        do_reset();
        lamp[11] = 3'b011;
        expect_out(1, 1'b0, 3'd0, 4'd0, "illegal_latency");
        expect_out(2, 1'b1, 3'd1, 4'd11, "illegal_l4");
        tick(3);
        lamp[11] = 3'b100;
        tick(2);
        fault_clr = 1'b1;
        expect_out(1, 1'b0, 3'd0, 4'd0, "clr_legal");
        tick(1);
        fault_clr = 1'b0;
        lamp[11] = 3'b011;
        expect_out(2, 1'b1, 3'd1, 4'd11, "illegal_again");
        tick(1);
        lamp[11] = 3'b100;
        lamp[IDX_C1] = 3'b001;
        lamp[1]      = 3'b001;
        tick(1);
        fault_clr = 1'b1;
        expect_out(1, 1'b1, 3'd2, 4'd1, "clr_vs_violation");
        tick(1);
        fault_clr = 1'b0;
        expect_out(2, 1'b1, 3'd2, 4'd1, "relatched_sticky");
        tick(3);

        // Reset mid-amber on r2, release with r2 red: no short amber.
        do_reset();
        lamp[IDX_R1 + 1] = 3'b001;
        tick(1);
        lamp[IDX_R1 + 1] = 3'b010;
        tick(1);
        rst = 1'b0;
        tick(1);
        lamp[IDX_R1 + 1] = 3'b100;
        rst = 1'b1;
        expect_out(1, 1'b0, 3'd0, 4'd0, "rst_mid_amber_1");
        expect_out(2, 1'b0, 3'd0, 4'd0, "rst_mid_amber_2");
        expect_out(3, 1'b0, 3'd0, 4'd0, "rst_mid_amber_3");
        tick(4);

        // Conflict held 5 samples, then f2 goes amber; count stays 5 through a clear.
        do_reset();
        lamp[IDX_F1] = 3'b001;
        lamp[1]      = 3'b001;
        tick(5);
        lamp[1] = 3'b010;
        push_exp(1, 1'b1, 3'd2, 4'd0, 1'b1, 16'd5, "count5_a");
        push_exp(2, 1'b1, 3'd2, 4'd0, 1'b1, 16'd5, "count5_b");
        tick(2);
        fault_clr = 1'b1;
        push_exp(1, 1'b0, 3'd0, 4'd0, 1'b1, 16'd5, "count_after_clr");
        tick(1);
        fault_clr = 1'b0;
        tick(3);

        for (int k = 0; k < 10 && sb.size() > 0; k++) tick(1);
        foreach (sb[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                     sb[i].name, sb[i].cyc, cyc_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Independent safety monitor on the receiving end of the traffic light controller's 16 lamp outputs (f1..f4, r1..r4, l1..l4, c1..c4).
- Samples every lamp vector each clock.
- Checks encoding, cross-movement conflicts and per-lamp sequencing (green -> amber -> red, minimum amber time).
- Latches the first violation and raises a fail-safe flash request for the board-level lamp driver.

Parameters:
MIN_AMBER, 3, minimum consecutive sampled cycles a lamp must show amber before red
CW, $clog2(MIN_AMBER+1), amber counter width (derived, localparam)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
f1,f2,f3,f4  input  3 each  forward lamps, approaches 1-4
r1,r2,r3,r4  input  3 each  right-turn lamps
l1,l2,l3,l4  input  3 each  left-turn lamps
c1,c2,c3,c4  input  3 each  pedestrian crossing lamps
fault_clr  input  1  synchronous clear of latched fault
fault  output  1  sticky fault flag
fault_code  output  3  code of latched fault
fault_lamp  output  4  index of lamp involved
flash_req  output  1  fail-safe flash request, equals fault

Behaviour:
- Lamp encoding: bit2 = red, bit1 = amber, bit0 = green.
  - Legal values: 3'b100, 3'b010, 3'b001. Anything else is ILLEGAL.
- Lamp index: f1..f4 = 0..3, r1..r4 = 4..7, l1..l4 = 8..11, c1..c4 = 12..15.
- Stage 1: all 16 inputs registered into cur[] every posedge. Previous cur copied into prv[]. prv_valid set one cycle after the first sample following reset.
- Stage 2: checks are combinational on cur/prv. A result is latched into fault/fault_code/fault_lamp at the next posedge.
- Latency: lamp values sampled at posedge N -> fault high after posedge N+1.
- Conflict rules (greens only, evaluated on cur):
  - any f/r/l green on approach 1 or 3 together with any f/r/l green on approach 2 or 4;
  - l_i green together with f of the opposing approach (1<->3, 2<->4) green;
  - any c green together with any f/r/l green.
- Sequence rules per lamp (only when prv_valid):
  - green -> red: SKIP_AMBER.
  - amber -> green: AMBER_GREEN.
  - amber -> red with amber count < MIN_AMBER: SHORT_AMBER.
- Amber counter per lamp:
  - loads 1 on entering amber, increments while amber, saturates at MIN_AMBER;
  - cleared when not amber.
- fault_code values: 0 NONE, 1 ILLEGAL, 2 CONFLICT, 3 SKIP_AMBER, 4 SHORT_AMBER, 5 AMBER_GREEN.
- Priority among simultaneous faults: lowest non-zero code wins, then lowest lamp index.
- For CONFLICT, fault_lamp is the lowest-index green lamp in the conflicting pair.
- Sticky: once fault = 1, later faults do not overwrite code or lamp.
- fault_clr:
  - clears fault/code/lamp to 0 at the next posedge;
  - if a new violation is detected in that same cycle, the new violation is latched instead (the violation wins).
- Reset (rst = 0, asynchronous):
  - fault = 0, fault_code = 0, fault_lamp = 0, flash_req = 0;
  - cur/prv = 3'b100 (all red), prv_valid = 0, counters = 0.
- First cycle after reset release: only ILLEGAL and CONFLICT checks are active.
- Reset mid-operation: all state is dropped and sequence checks restart as after power-up.

Optional Feature:
TLM_FAULT_COUNT_EN
- Defined: adds output fault_count[15:0]. It increments once per cycle in which any violation is detected, whether or not a fault is already latched. It saturates at 16'hFFFF, clears on reset, and is not affected by fault_clr.
- Undefined: the port and its logic are absent.

Decomposition:
- Package traffic_pkg: lamp encoding localparams (LAMP_RED/AMBER/GREEN), fault_code_t enum, lamp index constants, opposing-approach function.
- Sub-module lamp_seq_checker: one lamp's amber counter and sequence-rule check, with MIN_AMBER parameter. Instantiated 16 times via generate. Outputs are a per-lamp fault-code vector.

Test Plan:
- Reset, then f1 = 001 with all other lamps 100 for 10 cycles -> fault stays 0.
- f1 = 001 and f2 = 001 driven together -> fault = 1, fault_code = 2, fault_lamp = 0, two cycles after the sampling edge; flash_req = 1.
- f3: 001 -> 010 held 3 cycles -> 100 -> no fault. Repeat with amber held 2 cycles -> code 4, lamp 2.
- l4 = 3'b011 -> code 1, lamp 11. Then pulse fault_clr with legal lamps -> fault = 0. Pulse fault_clr while c1 is green and f2 is green -> re-latched, code 2, lamp 1.
- Assert rst low mid-amber on r2, release with r2 = 100 -> no SHORT_AMBER fault.
- With TLM_FAULT_COUNT_EN: hold a conflict for 5 cycles -> fault_count = 5. fault_clr leaves it at 5.
